// File: rtl/lsu_axi_gpio_wr_ctrl.sv
// AXI4 write-channel slave that maps LSU stores onto the user-area GPIO DATA/OE registers and LA mirror.
// Optional GPIO_WR_SLVERR_EN: SLVERR on unmapped addresses or bursts (awlen != 0).
module lsu_axi_gpio_wr_ctrl #(
    parameter int unsigned ID_W      = 3,
    parameter int unsigned GPIO_W    = 28,
    parameter logic [31:0] BASE_ADDR = 32'hD000_0000
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              axi_awvalid,
    output logic              axi_awready,
    input  logic [ID_W-1:0]   axi_awid,
    input  logic [31:0]       axi_awaddr,
    input  logic [7:0]        axi_awlen,
    input  logic              axi_wvalid,
    output logic              axi_wready,
    input  logic [63:0]       axi_wdata,
    input  logic [7:0]        axi_wstrb,
    input  logic              axi_wlast,
    output logic              axi_bvalid,
    input  logic              axi_bready,
    output logic [ID_W-1:0]   axi_bid,
    output logic [1:0]        axi_bresp,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oeb,
    output logic [31:0]       la_wr_data
);
    localparam int unsigned LANE_W = 32;
    localparam int unsigned LSTB_W = 4;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WAIT_W  = 3'd1;
    localparam logic [2:0] WAIT_AW = 3'd2;
    localparam logic [2:0] DRAIN   = 3'd3;
    localparam logic [2:0] WRITE   = 3'd4;
    localparam logic [2:0] RESP    = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ID_W-1:0]   awid_q;
    logic [31:0]       awaddr_q;
    logic [7:0]        awlen_q;
    logic [63:0]       wdata_q;
    logic [7:0]        wstrb_q;
    logic              wlast_q;
    logic              aw_hs, w_hs;
    logic [LANE_W-1:0] lane;
    logic [LSTB_W-1:0] lane_strb;
    logic              sel_data, sel_oe, wr_ok, do_wr;
    logic [1:0]        resp_code;
    logic              unused_bits;

    assign axi_awready = (state_q == IDLE) || (state_q == WAIT_AW);
    assign axi_wready  = (state_q == IDLE) || (state_q == WAIT_W) || (state_q == DRAIN);
    assign aw_hs       = axi_awvalid && axi_awready;
    assign w_hs        = axi_wvalid && axi_wready;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (aw_hs && w_hs) state_d = axi_wlast ? WRITE : DRAIN;
                else if (aw_hs)    state_d = WAIT_W;
                else if (w_hs)     state_d = WAIT_AW;
            end
            WAIT_W:  if (w_hs)  state_d = axi_wlast ? WRITE : DRAIN;
            WAIT_AW: if (aw_hs) state_d = wlast_q ? WRITE : DRAIN;
            DRAIN:   if (w_hs && axi_wlast) state_d = WRITE;
            WRITE:   state_d = RESP;
            RESP:    if (axi_bvalid && axi_bready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture AW fields and the first W beat only; drained beats are discarded.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            awid_q   <= '0;
            awaddr_q <= '0;
            awlen_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            wlast_q  <= 1'b0;
        end else begin
            if (aw_hs) begin
                awid_q   <= axi_awid;
                awaddr_q <= axi_awaddr;
                awlen_q  <= axi_awlen;
            end
            if (w_hs && (state_q != DRAIN)) begin
                wdata_q <= axi_wdata;
                wstrb_q <= axi_wstrb;
                wlast_q <= axi_wlast;
            end
        end
    end

    assign lane      = awaddr_q[2] ? wdata_q[63:32] : wdata_q[31:0];
    assign lane_strb = awaddr_q[2] ? wstrb_q[7:4]   : wstrb_q[3:0];
    assign sel_data  = (awaddr_q[31:12] == BASE_ADDR[31:12]) && (awaddr_q[11:3] == 9'd0);
    assign sel_oe    = (awaddr_q[31:12] == BASE_ADDR[31:12]) && (awaddr_q[11:3] == 9'd1);

`ifdef GPIO_WR_SLVERR_EN
    assign wr_ok     = (sel_data || sel_oe) && (awlen_q == 8'd0);
    assign resp_code = wr_ok ? 2'b00 : 2'b10;
`else
    assign wr_ok     = sel_data || sel_oe;
    assign resp_code = 2'b00;
`endif
    assign do_wr       = wr_ok && (|lane_strb);
    assign unused_bits = ^{awaddr_q[1:0], awlen_q};

    function automatic logic [LANE_W-1:0] merge_bytes(input logic [LANE_W-1:0] cur,
                                                      input logic [LANE_W-1:0] upd,
                                                      input logic [LSTB_W-1:0] strb);
        logic [LANE_W-1:0] res;
        res = cur;
        for (int k = 0; k < LSTB_W; k++)
            if (strb[k]) res[8*k +: 8] = upd[8*k +: 8];
        return res;
    endfunction

    // Register update and response launch at the closing edge of WRITE.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            gpio_out   <= '0;
            gpio_oeb   <= '1;
            la_wr_data <= '0;
            axi_bvalid <= 1'b0;
            axi_bid    <= '0;
            axi_bresp  <= 2'b00;
        end else if (state_q == WRITE) begin
            if (do_wr) begin
                la_wr_data <= lane;
                if (sel_data)
                    gpio_out <= GPIO_W'(merge_bytes(LANE_W'(gpio_out), lane, lane_strb));
                if (sel_oe)
                    gpio_oeb <= ~GPIO_W'(merge_bytes(LANE_W'(~gpio_oeb), lane, lane_strb));
            end
            axi_bvalid <= 1'b1;
            axi_bid    <= awid_q;
            axi_bresp  <= resp_code;
        end else if ((state_q == RESP) && axi_bready) begin
            axi_bvalid <= 1'b0;
        end
    end
endmodule
